// File: rtl/ibex_cheri_cap_lsu_seq_pkg.sv
// rtl/ibex_cheri_cap_lsu_seq_pkg.sv - shared types and constants for the capability LSU sequencer
package ibex_cheri_cap_lsu_seq_pkg;

  typedef enum logic [2:0] {
    CS_IDLE,
    CS_REQ_LO,
    CS_WAIT_LO,
    CS_REQ_HI,
    CS_WAIT_HI,
    CS_DONE
  } cap_seq_state_e;

  localparam logic [3:0] CAP_BEAT_BE   = 4'b1111;
  localparam logic [1:0] CAP_DATA_TYPE = 2'b11;

endpackage

// File: rtl/ibex_cheri_cap_lsu_seq.sv
// rtl/ibex_cheri_cap_lsu_seq.sv - splits a 64-bit capability access into two 32-bit bus beats
module ibex_cheri_cap_lsu_seq
  import ibex_cheri_cap_lsu_seq_pkg::*;
#(
  parameter int unsigned CapMemWidth = 64,
  parameter bit          AbortOnErr  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [31:0]            addr_i,
  input  logic [CapMemWidth-1:0] wdata_i,
  input  logic                   wtag_i,
  output logic                   ready_o,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  input  logic                   data_rvalid_i,
  input  logic                   data_err_i,
  output logic [31:0]            data_addr_o,
  output logic                   data_we_o,
  output logic [3:0]             data_be_o,
  output logic [1:0]             data_type_o,
  output logic                   data_cap_o,
  output logic                   data_first_access_o,
  output logic [31:0]            data_wdata_o,
  output logic                   data_wtag_o,
  input  logic [31:0]            data_rdata_i,
  input  logic                   data_rtag_i,
  input  logic                   cheri_exc_i,
  output logic                   done_o,
  output logic [CapMemWidth-1:0] rdata_o,
  output logic                   rtag_o,
  output logic                   err_o,
  output logic                   cheri_err_o,
  output logic                   misaligned_o
);

  cap_seq_state_e         state_q, state_d;
  logic                   we_q, we_d;
  logic [31:3]            addr_q, addr_d;
  logic [CapMemWidth-1:0] wdata_q, wdata_d;
  logic                   wtag_q, wtag_d;
  logic [31:0]            lo_q, lo_d;
  logic                   tag_lo_q, tag_lo_d;
  logic                   err_acc_q, err_acc_d;
  logic                   cheri_acc_q, cheri_acc_d;
  logic [CapMemWidth-1:0] rdata_q, rdata_d;
  logic                   rtag_q, rtag_d;
  logic                   err_q, err_d;
  logic                   cheri_q, cheri_d;
  logic                   mis_q, mis_d;
  logic                   hi_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CS_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wtag_q      <= 1'b0;
      lo_q        <= '0;
      tag_lo_q    <= 1'b0;
      err_acc_q   <= 1'b0;
      cheri_acc_q <= 1'b0;
      rdata_q     <= '0;
      rtag_q      <= 1'b0;
      err_q       <= 1'b0;
      cheri_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wtag_q      <= wtag_d;
      lo_q        <= lo_d;
      tag_lo_q    <= tag_lo_d;
      err_acc_q   <= err_acc_d;
      cheri_acc_q <= cheri_acc_d;
      rdata_q     <= rdata_d;
      rtag_q      <= rtag_d;
      err_q       <= err_d;
      cheri_q     <= cheri_d;
      mis_q       <= mis_d;
    end
  end

  // Result registers only change on entry to CS_DONE so they hold between completions.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wtag_d      = wtag_q;
    lo_d        = lo_q;
    tag_lo_d    = tag_lo_q;
    err_acc_d   = err_acc_q;
    cheri_acc_d = cheri_acc_q;
    rdata_d     = rdata_q;
    rtag_d      = rtag_q;
    err_d       = err_q;
    cheri_d     = cheri_q;
    mis_d       = mis_q;
    hi_err      = err_acc_q | data_err_i;
    unique case (state_q)
      CS_IDLE: begin
        if (req_i) begin
          we_d        = we_i;
          addr_d      = addr_i[31:3];
          wdata_d     = wdata_i;
          wtag_d      = wtag_i;
          err_acc_d   = 1'b0;
          cheri_acc_d = 1'b0;
          if (addr_i[2:0] != 3'b000) begin
            rdata_d = '0;
            rtag_d  = 1'b0;
            err_d   = 1'b0;
            cheri_d = 1'b0;
            mis_d   = 1'b1;
            state_d = CS_DONE;
          end else begin
            state_d = CS_REQ_LO;
          end
        end
      end
      CS_REQ_LO: if (data_gnt_i) state_d = CS_WAIT_LO;
      CS_WAIT_LO: begin
        if (data_rvalid_i) begin
          lo_d        = data_rdata_i;
          tag_lo_d    = data_rtag_i;
          err_acc_d   = data_err_i;
          cheri_acc_d = cheri_exc_i;
          if (AbortOnErr && (data_err_i || cheri_exc_i)) begin
            rdata_d = '0;
            rtag_d  = 1'b0;
            err_d   = data_err_i;
            cheri_d = cheri_exc_i;
            mis_d   = 1'b0;
            state_d = CS_DONE;
          end else begin
            state_d = CS_REQ_HI;
          end
        end
      end
      CS_REQ_HI: if (data_gnt_i) state_d = CS_WAIT_HI;
      CS_WAIT_HI: begin
        if (data_rvalid_i) begin
          err_d   = hi_err;
          cheri_d = cheri_acc_q;
          mis_d   = 1'b0;
          rtag_d  = tag_lo_q & ~hi_err & ~cheri_acc_q;
          rdata_d = (hi_err || cheri_acc_q) ? '0 : {data_rdata_i, lo_q};
          state_d = CS_DONE;
        end
      end
      CS_DONE: state_d = CS_IDLE;
      default: state_d = CS_IDLE;
    endcase
  end

  logic req_lo, req_hi;
  assign req_lo = (state_q == CS_REQ_LO);
  assign req_hi = (state_q == CS_REQ_HI);

  assign ready_o             = (state_q == CS_IDLE);
  assign done_o              = (state_q == CS_DONE);
  assign data_req_o          = req_lo | req_hi;
  assign data_first_access_o = req_lo;
  assign data_cap_o          = (state_q == CS_REQ_LO) || (state_q == CS_WAIT_LO) ||
                               (state_q == CS_REQ_HI) || (state_q == CS_WAIT_HI);
  assign data_addr_o         = req_lo ? {addr_q, 3'b000} : (req_hi ? {addr_q, 3'b100} : 32'h0);
  assign data_we_o           = data_req_o & we_q;
  assign data_wdata_o        = req_lo ? wdata_q[31:0] : (req_hi ? wdata_q[63:32] : 32'h0);
  assign data_wtag_o         = req_lo & wtag_q;
  assign data_be_o           = data_cap_o ? CAP_BEAT_BE : 4'b0000;
  assign data_type_o         = data_cap_o ? CAP_DATA_TYPE : 2'b00;
  assign rdata_o             = rdata_q;
  assign rtag_o              = rtag_q;
  assign err_o               = err_q;
  assign cheri_err_o         = cheri_q;
  assign misaligned_o        = mis_q;

endmodule

// File: tb/tb_ibex_cheri_cap_lsu_seq.sv
// tb/tb_ibex_cheri_cap_lsu_seq.sv - self-checking bench for the capability LSU sequencer
module tb_ibex_cheri_cap_lsu_seq;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i, wtag_i;
  logic [31:0] addr_i;
  logic [63:0] wdata_i;
  logic        ready_o, data_req_o, data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        data_we_o, data_cap_o, data_first_access_o, data_wtag_o;
  logic [3:0]  data_be_o;
  logic [1:0]  data_type_o;
  logic        data_rtag_i, cheri_exc_i, done_o;
  logic [63:0] rdata_o;
  logic        rtag_o, err_o, cheri_err_o, misaligned_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_cheri_cap_lsu_seq dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wtag_i(wtag_i), .ready_o(ready_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_type_o(data_type_o), .data_cap_o(data_cap_o),
    .data_first_access_o(data_first_access_o), .data_wdata_o(data_wdata_o),
    .data_wtag_o(data_wtag_o), .data_rdata_i(data_rdata_i), .data_rtag_i(data_rtag_i),
    .cheri_exc_i(cheri_exc_i), .done_o(done_o), .rdata_o(rdata_o), .rtag_o(rtag_o),
    .err_o(err_o), .cheri_err_o(cheri_err_o), .misaligned_o(misaligned_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    cheri_exc_i = 1'b0; data_rdata_i = $urandom; data_rtag_i = 1'($urandom);
  endtask

  // One capability access against a bus responder with per-beat grant delays and errors.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                         input logic wt, input int d0, input int d1,
                         input logic e0, input logic x0, input logic e1,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic t0, input logic t1);
    logic [31:0] o_addr[2], o_wd[2];
    logic        o_we[2], o_wt[2], o_first[2];
    logic [3:0]  o_be[2];
    logic [1:0]  o_type[2];
    logic [31:0] hold_addr, hold_wd, base;
    logic [63:0] res_rd, exp_rd;
    logic        res_tag, res_err, res_cheri, res_mis;
    logic        mis, abort, exp_err, exp_cheri, exp_tag, any_err, in_req, rv_pend;
    int          nreq, nrv, wait_cnt, cyc, done_cyc, unstable, exp_beats, exp_cyc;

    mis       = (addr[2:0] != 3'b000);
    abort     = e0 | x0;
    base      = {addr[31:3], 3'b000};
    exp_beats = mis ? 0 : (abort ? 1 : 2);
    exp_cyc   = mis ? 2 : (abort ? d0 + 4 : d0 + d1 + 6);
    exp_err   = !mis && (e0 || (!abort && e1));
    exp_cheri = !mis && x0;
    any_err   = mis | exp_err | exp_cheri;
    exp_rd    = any_err ? 64'h0 : {r1, r0};
    exp_tag   = any_err ? 1'b0 : t0;

    @(negedge clk);
    chk("ready_before_req", ready_o, 1'b1);
    idle_inputs();
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; wtag_i = wt;
    data_rvalid_i = 1'b1; data_err_i = 1'b1; cheri_exc_i = 1'b1;
    cyc = 1; nreq = 0; nrv = 0; wait_cnt = 0; done_cyc = 0; unstable = 0;
    in_req = 1'b0; rv_pend = 1'b0;
    res_rd = '0; res_tag = 0; res_err = 0; res_cheri = 0; res_mis = 0;
    hold_addr = '0; hold_wd = '0;
    for (int i = 0; i < 2; i++) begin
      o_addr[i] = '0; o_wd[i] = '0; o_we[i] = 0; o_wt[i] = 0; o_first[i] = 0;
      o_be[i] = '0; o_type[i] = '0;
    end

    for (int k = 0; k < 40 && done_cyc == 0; k++) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      we_i = 1'($urandom); addr_i = $urandom; wdata_i = {$urandom, $urandom}; wtag_i = 1'($urandom);
      if (rv_pend) begin
        rv_pend       = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = (nrv == 0) ? r0 : r1;
        data_rtag_i   = (nrv == 0) ? t0 : t1;
        data_err_i    = (nrv == 0) ? e0 : e1;
        cheri_exc_i   = (nrv == 0) ? x0 : 1'b0;
        nrv++;
      end
      if (data_req_o) begin
        if (!in_req) begin
          in_req = 1'b1; wait_cnt = 0;
          if (nreq < 2) begin
            o_addr[nreq] = data_addr_o; o_wd[nreq] = data_wdata_o; o_we[nreq] = data_we_o;
            o_wt[nreq] = data_wtag_o; o_first[nreq] = data_first_access_o;
            o_be[nreq] = data_be_o; o_type[nreq] = data_type_o;
          end
          hold_addr = data_addr_o; hold_wd = data_wdata_o;
          nreq++;
        end else if (data_addr_o !== hold_addr || data_wdata_o !== hold_wd) begin
          unstable++;
        end
        if (wait_cnt == ((nreq == 1) ? d0 : d1)) begin
          data_gnt_i = 1'b1; in_req = 1'b0; rv_pend = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      if (done_o) begin
        done_cyc = cyc;
        res_rd = rdata_o; res_tag = rtag_o; res_err = err_o;
        res_cheri = cheri_err_o; res_mis = misaligned_o;
      end
    end

    @(negedge clk);
    idle_inputs();
    chk("done_pulse_width", done_o, 1'b0);
    chk("ready_after_done", ready_o, 1'b1);
    chk("result_held", rdata_o, res_rd);

    chk("beat_count", nreq, exp_beats);
    chk("done_cycle", done_cyc, exp_cyc);
    chk("beat_stable", unstable, 0);
    for (int i = 0; i < 2; i++) begin
      if (i < exp_beats && i < nreq) begin
        chk($sformatf("beat%0d_addr", i), o_addr[i], base + 32'(4 * i));
        chk($sformatf("beat%0d_we", i), o_we[i], we);
        chk($sformatf("beat%0d_wdata", i), o_wd[i], (i == 0) ? wd[31:0] : wd[63:32]);
        chk($sformatf("beat%0d_wtag", i), o_wt[i], (i == 0) ? wt : 1'b0);
        chk($sformatf("beat%0d_first", i), o_first[i], (i == 0));
        chk($sformatf("beat%0d_be_type", i), {o_be[i], o_type[i]}, 6'b1111_11);
      end
    end
    chk("err", res_err, exp_err);
    chk("cheri_err", res_cheri, exp_cheri);
    chk("misaligned", res_mis, mis);
    if (!we) begin
      chk("rdata", res_rd, exp_rd);
      chk("rtag", res_tag, exp_tag);
    end
  endtask

  initial begin
    rst_i = 1'b1; we_i = 0; addr_i = '0; wdata_i = '0; wtag_i = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_ready", ready_o, 1'b1);
    chk("reset_req", data_req_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_rdata", rdata_o, 64'h0);
    chk("reset_flags", {rtag_o, err_o, cheri_err_o, misaligned_o}, 4'b0000);
    chk("reset_beat_outs", {data_cap_o, data_first_access_o, data_we_o, data_wtag_o}, 4'b0000);
    chk("reset_addr", data_addr_o, 32'h0);
    rst_i = 1'b0;

    run_txn(1'b0, 32'h0000_1000, 64'h0, 1'b0, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h2222_2222, 1, 0);
    run_txn(1'b1, 32'h0000_2008, 64'hAABBCCDD_11223344, 1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    run_txn(1'b0, 32'h0000_5000, 64'h0, 1'b0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1);
    run_txn(1'b0, 32'h0000_3004, 64'h0, 1'b0, 0, 0, 0, 0, 0, 32'h5555_5555, 32'h6666_6666, 1, 0);
    run_txn(1'b0, 32'h0000_6010, 64'h0, 1'b0, 0, 3, 0, 0, 1, 32'h7777_7777, 32'h8888_8888, 1, 0);
    run_txn(1'b0, 32'hFFFF_FFF8, 64'h0, 1'b0, 1, 0, 0, 0, 0, 32'h0BAD_F00D, 32'hCAFE_0001, 1, 0);
    run_txn(1'b0, 32'h0000_7000, 64'h0, 1'b0, 2, 1, 1, 0, 0, 32'h9999_9999, 32'hAAAA_AAAA, 1, 0);

    // Reset while waiting on the upper beat.
    @(negedge clk);
    idle_inputs();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_4000;
    @(negedge clk); idle_inputs(); data_gnt_i = 1'b1;
    @(negedge clk); idle_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'h1357_9BDF; data_rtag_i = 1'b1;
    @(negedge clk); idle_inputs(); data_gnt_i = 1'b1;
    @(negedge clk); idle_inputs();
    chk("wait_hi_cap_active", {data_cap_o, data_req_o}, 2'b10);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_rst_ready", ready_o, 1'b1);
    chk("mid_rst_req", data_req_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    run_txn(1'b0, 32'h0000_4000, 64'h0, 1'b0, 0, 0, 0, 0, 0, 32'h0102_0304, 32'h0506_0708, 1, 1);

    for (int n = 0; n < 25; n++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFF8;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 7));
      run_txn(1'($urandom), a, {$urandom, $urandom}, 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              $urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
